// File: rtl/sfu_accum_bank_pkg.sv
// rtl/sfu_accum_bank_pkg.sv - shared types for the multi-pass psum accumulator bank
//
// Purpose: FSM state encoding used by sfu_accum_bank.
// Ports:   none (package).

package sfu_accum_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sfu_lane_acc.sv
// rtl/sfu_lane_acc.sv - one lane of the accumulator bank: saturating add and ReLU read mux
//
// Purpose: purely combinational per-lane datapath.
// Ports:
//   acc     in   current bank value for the pixel being written
//   din     in   incoming psum for this lane
//   bypass  in   first pass: store din unmodified (no add, no saturation)
//   rd      in   bank value for the pixel being drained
//   relu_en in   clamp negative drain values to zero
//   wr      out  value to store back into the bank
//   sat     out  the add was clamped this cycle
//   rd_out  out  drain value after optional ReLU

module sfu_lane_acc #(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] acc,
  input  logic [psum_bw-1:0] din,
  input  logic               bypass,
  input  logic [psum_bw-1:0] rd,
  input  logic               relu_en,
  output logic [psum_bw-1:0] wr,
  output logic               sat,
  output logic [psum_bw-1:0] rd_out
);

  localparam logic [psum_bw-1:0] MAX_V = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] MIN_V = {1'b1, {(psum_bw-1){1'b0}}};

  // One extra bit holds the true sum; overflow iff the top two bits disagree,
  // and the top bit then gives the direction of the overflow.
  logic [psum_bw:0] sum;
  assign sum = {acc[psum_bw-1], acc} + {din[psum_bw-1], din};

  always_comb begin
    wr  = din;
    sat = 1'b0;
    if (!bypass) begin
      if (sum[psum_bw] != sum[psum_bw-1]) begin
        sat = 1'b1;
        wr  = sum[psum_bw] ? MIN_V : MAX_V;
      end else begin
        wr = sum[psum_bw-1:0];
      end
    end
  end

  // ReLU only shapes the drained value; the stored value is untouched.
  assign rd_out = (relu_en && rd[psum_bw-1]) ? '0 : rd;

endmodule

// File: rtl/sfu_accum_bank.sv
// rtl/sfu_accum_bank.sv - multi-pass psum accumulator bank with saturating lanes and ReLU drain
//
// Purpose: accumulates num_pass passes of num_pix col-lane psum vectors into a
//   bank, then drains the bank over a valid/ready handshake.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 pulse, honoured only when idle; latches num_pass/num_pix/relu_en
//   num_pass, num_pix     run configuration (0 means 1; num_pix above DEPTH clamps to DEPTH)
//   relu_en               ReLU on drain
//   in_valid/in_ready/in_data     psum vector input
//   out_valid/out_ready/out_data  drained vector output (out_data is 0 when not valid)
//   busy, done            not idle; one-cycle pulse after the last drain
//   sat_flag              sticky saturation indicator, cleared by an accepted start

module sfu_accum_bank
  import sfu_accum_bank_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int DEPTH   = 16,
  parameter int PASS_W  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PASS_W-1:0]        num_pass,
  input  logic [ADDR_W:0]          num_pix,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]      pix, rd;
  logic [PASS_W-1:0]      pass;
  logic [ADDR_W:0]        cfg_last_pix;
  logic [PASS_W-1:0]      cfg_last_pass;
  logic                   cfg_relu;
  logic [ADDR_W:0]        npix_eff;

  logic [col*psum_bw-1:0] bank [DEPTH];
  logic [col*psum_bw-1:0] wr_vec, rd_vec;
  logic [col-1:0]         lane_sat;

  logic in_hs, out_hs, pix_last, pass_last, rd_last;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign pix_last  = ({1'b0, pix} == cfg_last_pix);
  assign pass_last = (pass == cfg_last_pass);
  assign rd_last   = ({1'b0, rd} == cfg_last_pix);

  always_comb begin
    npix_eff = num_pix;
    if (num_pix == '0)
      npix_eff = (ADDR_W+1)'(1);
    else if (num_pix > DEPTH_V)
      npix_eff = DEPTH_V;
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfu_lane_acc #(.psum_bw(psum_bw)) u_lane (
      .acc     (bank[pix][i*psum_bw +: psum_bw]),
      .din     (in_data[i*psum_bw +: psum_bw]),
      .bypass  (pass == '0),
      .rd      (bank[rd][i*psum_bw +: psum_bw]),
      .relu_en (cfg_relu),
      .wr      (wr_vec[i*psum_bw +: psum_bw]),
      .sat     (lane_sat[i]),
      .rd_out  (rd_vec[i*psum_bw +: psum_bw])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && pix_last && pass_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && rd_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign out_data = out_valid ? rd_vec : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix           <= '0;
      pass          <= '0;
      rd            <= '0;
      cfg_last_pix  <= '0;
      cfg_last_pass <= '0;
      cfg_relu      <= 1'b0;
      sat_flag      <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        cfg_last_pix  <= npix_eff - (ADDR_W+1)'(1);
        cfg_last_pass <= (num_pass == '0) ? '0 : num_pass - PASS_W'(1);
        cfg_relu      <= relu_en;
        sat_flag      <= 1'b0;
        pix           <= '0;
        pass          <= '0;
        rd            <= '0;
      end
      if (in_hs) begin
        if (pix_last) begin
          pix  <= '0;
          pass <= pass + PASS_W'(1);
        end else begin
          pix <= pix + ADDR_W'(1);
        end
        // lane_sat is never set on the first pass, so no extra gating needed.
        if (|lane_sat) sat_flag <= 1'b1;
      end
      if (out_hs) rd <= rd + ADDR_W'(1);
    end
  end

  // Bank storage is deliberately not reset: the first pass overwrites every used entry.
  always_ff @(posedge clk) begin
    if (in_hs) bank[pix] <= wr_vec;
  end

endmodule

// File: tb/tb_sfu_accum_bank.sv
// tb/tb_sfu_accum_bank.sv - self-checking bench for sfu_accum_bank (col=2, psum_bw=16, DEPTH=4)

module tb_sfu_accum_bank;

  localparam int COL    = 2;
  localparam int BW     = 16;
  localparam int DEPTH  = 4;
  localparam int PASS_W = 4;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              reset, start, relu_en, in_valid, out_ready;
  logic [PASS_W-1:0] num_pass;
  logic [AW:0]       num_pix;
  logic [COL*BW-1:0] in_data;
  logic              in_ready, out_valid, busy, done, sat_flag;
  logic [COL*BW-1:0] out_data;

  sfu_accum_bank #(.col(COL), .psum_bw(BW), .DEPTH(DEPTH), .PASS_W(PASS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pass(num_pass), .num_pix(num_pix),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int drain_cnt = 0;
  int last_hs_cyc = -100;
  logic [31:0] stim_q[$];
  logic [31:0] exp_q[$];
  bit          exp_sat;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mk(int a, int b);
    return {b[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer accumulation over the whole stimulus list.
  task automatic build_exp(input int np, input int npix, input bit relu);
    int acc[DEPTH][COL];
    int np_e, px, s;
    logic [31:0] v;
    np_e = (np == 0) ? 1 : np;
    px   = (npix == 0) ? 1 : ((npix > DEPTH) ? DEPTH : npix);
    exp_sat = 1'b0;
    exp_q.delete();
    for (int p = 0; p < np_e; p++)
      for (int x = 0; x < px; x++) begin
        v = stim_q[p*px + x];
        for (int l = 0; l < COL; l++) begin
          s = $signed(v[l*BW +: BW]);
          if (p > 0) begin
            s = s + acc[x][l];
            if (s > 32767)  begin s = 32767;  exp_sat = 1'b1; end
            if (s < -32768) begin s = -32768; exp_sat = 1'b1; end
          end
          acc[x][l] = s;
        end
      end
    for (int x = 0; x < px; x++) begin
      int a0, a1;
      a0 = acc[x][0];
      a1 = acc[x][1];
      if (relu && a0 < 0) a0 = 0;
      if (relu && a1 < 0) a1 = 0;
      exp_q.push_back(mk(a0, a1));
    end
  endtask

  // Compare process: every drain handshake, idle output, stall and done pulse.
  always @(negedge clk) begin
    if (!out_valid) begin
      check("out_data_zero_when_invalid", out_data, 32'd0);
    end else begin
      if (prev_stall) check("stall_stable", out_data, prev_data);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output: got %h expected no output", out_data);
        end else begin
          check("drain_data", out_data, exp_q.pop_front());
        end
        drain_cnt++;
        last_hs_cyc = cyc;
      end
    end
    if (done) check("done_after_last_drain", 32'(cyc - last_hs_cyc), 32'd1);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic start_run(input int np, input int npix, input bit relu);
    build_exp(np, npix, relu);
    @(posedge clk); #1;
    start    = 1'b1;
    num_pass = PASS_W'(np);
    num_pix  = (AW+1)'(npix);
    relu_en  = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_all(input bit gap);
    int n;
    foreach (stim_q[i]) begin
      in_data  = stim_q[i];
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got 0 expected 1");
    end else begin
      check("busy_in_done", busy, 1'b1);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      check("sat_flag", sat_flag, exp_sat);
      check("all_drained", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, base;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; num_pass = '0; num_pix = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: idle after reset, then async reset without a clock edge
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sat_flag", sat_flag, 1'b0);
    stim_q = '{mk(1, 1), mk(2, 2)};
    start_run(1, 2, 1'b0);
    @(negedge clk);
    check("accum_in_ready", in_ready, 1'b1);
    check("accum_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_in_ready", in_ready, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;

    // 2: two passes, two pixels
    stim_q = '{mk(3, -5), mk(7, 1), mk(10, -2), mk(-4, 4)};
    start_run(2, 2, 1'b0);
    check("model_t2_px0", exp_q[0], mk(13, -7));
    check("model_t2_px1", exp_q[1], mk(3, 5));
    send_all(1'b0);
    wait_done();

    // 3: same stream with ReLU; a start while busy is ignored
    start_run(2, 2, 1'b1);
    check("model_t3_px0", exp_q[0], mk(13, 0));
    @(posedge clk); #1;
    start = 1'b1; num_pass = PASS_W'(1); num_pix = (AW+1)'(1); relu_en = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    send_all(1'b0);
    wait_done();

    // 4: saturation in both directions
    stim_q = '{mk(32000, -32000), mk(1000, -1000)};
    start_run(2, 1, 1'b0);
    check("model_t4_px0", exp_q[0], mk(32767, -32768));
    check("model_t4_sat", exp_sat, 1'b1);
    send_all(1'b0);
    wait_done();
    @(negedge clk);
    check("sat_sticky_idle", sat_flag, 1'b1);

    // 5: in_valid gaps and output backpressure
    stim_q.delete();
    for (int i = 0; i < 12; i++) stim_q.push_back(mk(i*1000 - 5000, 300 - i*97));
    start_run(3, 4, 1'b0);
    check("sat_cleared_on_start", sat_flag, 1'b0);
    out_ready = 1'b0;
    send_all(1'b1);
    @(negedge clk);
    check("drain_latency", out_valid, 1'b1);
    check("in_ready_dropped", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();

    // 6: reset during drain after one of four outputs
    stim_q = '{mk(11, -11), mk(22, -22), mk(33, -33), mk(44, -44)};
    start_run(1, 4, 1'b0);
    base = drain_cnt;
    send_all(1'b0);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (drain_cnt < base + 1 && n < 100);
    check("t6_one_drained", 32'(drain_cnt - base), 32'd1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_out_data", out_data, 32'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    stim_q = '{mk(-7, 9), mk(100, -200)};
    start_run(1, 2, 1'b0);
    check("model_t6_px1", exp_q[1], mk(100, -200));
    send_all(1'b0);
    wait_done();

    // 7: num_pass=0 acts as 1, num_pix=7 clamps to DEPTH, ReLU on
    stim_q = '{mk(-1, 2), mk(5, -6), mk(-32768, 32767), mk(0, -1)};
    start_run(0, 7, 1'b1);
    check("model_t7_px2", exp_q[2], mk(0, 32767));
    check("model_t7_len", exp_q.size(), 32'd4);
    send_all(1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
